// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipeline register chain.
package pipe_pkg;

  localparam logic        BUBBLE_VALID   = 1'b0;
  localparam logic [63:0] BUBBLE_PAYLOAD = 64'd0;

  function automatic int occ_width(input int stages);
    return $clog2(stages + 1);
  endfunction

  // Counter widths up to 64 bits; the result sticks at the all-ones value of 'width'.
  function automatic logic [63:0] sat_inc(input logic [63:0] count, input int width);
    logic [63:0] max_val;
    if (width >= 64) max_val = '1;
    else             max_val = (64'd1 << width) - 64'd1;
    return (count >= max_val) ? max_val : count + 64'd1;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline slot: reset and flush load a bubble, hold keeps contents, otherwise load the source.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_hold,
  input  logic             i_src_valid,
  input  logic [WIDTH-1:0] i_src_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_valid <= BUBBLE_VALID;
      r_data  <= WIDTH'(BUBBLE_PAYLOAD);
    end else if (!i_hold) begin
      r_valid <= i_src_valid;
      r_data  <= i_src_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_reg_chain.sv
// Parametrised chain of pipeline registers with stall, flush, bubble insertion,
// occupancy reporting and a saturating stall-bubble counter.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        in_ready,
  input  logic [STAGES-1:0]           stall,
  input  logic [STAGES-1:0]           flush,
  output logic [STAGES-1:0]           stage_valid,
  output logic [STAGES*WIDTH-1:0]     stage_data,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  output logic [$clog2(STAGES+1)-1:0] occupancy,
  output logic [CNT_W-1:0]            bubble_count
);

  localparam int OCC_W = occ_width(STAGES);

  logic [STAGES-1:0] w_hold;
  logic [STAGES-1:0] w_bubble_vec;
  logic [OCC_W-1:0]  w_occ;
  logic [CNT_W-1:0]  r_bubble_count;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             w_src_valid;
    logic [WIDTH-1:0] w_src_data;

    // A stalled later stage freezes everything upstream of it.
    assign w_hold[k] = |(stall >> k);

    if (k == 0) begin : g_first
      assign w_src_valid     = in_valid;
      assign w_src_data      = in_valid ? in_data : WIDTH'(BUBBLE_PAYLOAD);
      assign w_bubble_vec[k] = 1'b0;
    end else begin : g_rest
      logic w_insert;
      // A frozen upstream stage feeds a bubble, unless it is being flushed,
      // in which case its old contents move on as it empties.
      assign w_insert        = w_hold[k-1] & ~flush[k-1];
      assign w_src_valid     = w_insert ? BUBBLE_VALID : stage_valid[k-1];
      assign w_src_data      = w_insert ? WIDTH'(BUBBLE_PAYLOAD)
                                        : stage_data[(k-1)*WIDTH +: WIDTH];
      assign w_bubble_vec[k] = w_insert & ~w_hold[k] & ~flush[k];
    end

    pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .i_flush    (flush[k]),
      .i_hold     (w_hold[k]),
      .i_src_valid(w_src_valid),
      .i_src_data (w_src_data),
      .o_valid    (stage_valid[k]),
      .o_data     (stage_data[k*WIDTH +: WIDTH])
    );
  end

  always_comb begin
    w_occ = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_occ = w_occ + OCC_W'(stage_valid[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bubble_count <= '0;
    end else if (|w_bubble_vec) begin
      r_bubble_count <= CNT_W'(sat_inc(64'(r_bubble_count), CNT_W));
    end
  end

  assign in_ready     = ~w_hold[0] & ~reset;
  assign out_valid    = stage_valid[STAGES-1];
  assign out_data     = stage_data[(STAGES-1)*WIDTH +: WIDTH];
  assign occupancy    = w_occ;
  assign bubble_count = r_bubble_count;

endmodule
